btn_entry_tx: RTL and testbench

Front-end that turns the raw DE2-115 push-buttons into the clean code stream the safe lock FSM consumes. The lock FSM compares `btn[3:0]` every cycle and treats zero as idle, so it needs exactly one nonzero cycle per user entry. This block does the following for each entry:
- synchronizes and debounces the four active-low keys;
- accumulates a multi-key chord;
- waits for full release;
- drives the accumulated 4-bit code for exactly one clock, and holds zero at all other times.

---
 rtl/btn_entry_tx.sv | 196 +++++++++++++++++++
 tb/tb_btn_entry_tx.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/btn_entry_tx.sv
// btn_entry_tx: conditions the four active-low DE2-115 keys and turns each
// user entry (single key or chord) into a one-cycle code for the lock FSM.
// Keys are synchronized and debounced, then pressed keys are ORed together
// inside a chord window. After a full release the code is emitted once, or
// discarded when the lock is in lockout.
module btn_entry_tx #(
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int CHORD_CYCLES    = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_n,
  input  logic       lock_active,
  output logic [3:0] btn,
  output logic       code_valid,
  output logic       dropped,
  output logic       busy
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CW = $clog2(CHORD_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CHORD_LAST = CW'(CHORD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_WAIT_RELEASE,
    S_EMIT
  } state_t;

  // ---------------------------------------------------------------------
  // Two-flop synchronizer; reset value is "all keys released" (high).
  // ---------------------------------------------------------------------
  logic [3:0] sync1_q, sync1_d;
  logic [3:0] sync2_q, sync2_d;
  logic [3:0] pressed;

  // Next values of the synchronizer chain.
  always_comb begin
    sync1_d = key_n;
    sync2_d = sync1_q;
  end

  // Synchronizer registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 4'b1111;
      sync2_q <= 4'b1111;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign pressed = ~sync2_q;

  // ---------------------------------------------------------------------
  // Per-key debounce: the debounced level follows the synchronized level
  // only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  // ---------------------------------------------------------------------
  logic [3:0] deb_q, deb_d;

  for (genvar gi = 0; gi < 4; gi++) begin : g_deb
    logic [DW-1:0] cnt_q, cnt_d;
    logic          deb_bit_d;

    // Count disagreeing samples; flip the level on the last one.
    always_comb begin
      cnt_d     = '0;
      deb_bit_d = deb_q[gi];
      if (pressed[gi] != deb_q[gi]) begin
        if (cnt_q == DEB_LAST) begin
          deb_bit_d = pressed[gi];
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
    end

    // Debounce counter register.
    always_ff @(posedge clk) begin
      if (!rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign deb_d[gi] = deb_bit_d;
  end

  // Debounced key levels (1 = pressed).
  always_ff @(posedge clk) begin
    if (!rst) begin
      deb_q <= 4'b0000;
    end else begin
      deb_q <= deb_d;
    end
  end

  // ---------------------------------------------------------------------
  // Entry FSM with chord accumulator and chord-window timer.
  // ---------------------------------------------------------------------
  state_t        state_q, state_d;
  logic [3:0]    acc_q, acc_d;
  logic [CW-1:0] timer_q, timer_d;
  logic [3:0]    btn_q, btn_d;
  logic          code_valid_q, code_valid_d;
  logic          dropped_q, dropped_d;
  logic          emit_now;

  // Next-state, accumulator, timer and registered-output logic.
  // The output flops load on the edge that enters EMIT, so the code (or the
  // drop pulse) is visible exactly during the EMIT cycle; lock_active is
  // captured at that same edge, i.e. it decides only the emission itself.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    timer_d      = timer_q;
    btn_d        = 4'b0000;
    code_valid_d = 1'b0;
    dropped_d    = 1'b0;
    emit_now     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (deb_q != 4'b0000) begin
          acc_d   = deb_q;
          timer_d = '0;
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        acc_d   = acc_q | deb_q;
        timer_d = timer_q + CW'(1);
        // Release wins over window expiry in the same cycle.
        if (deb_q == 4'b0000) begin
          state_d  = S_EMIT;
          emit_now = 1'b1;
        end else if (timer_q == CHORD_LAST) begin
          state_d = S_WAIT_RELEASE;
        end
      end
      S_WAIT_RELEASE: begin
        // Accumulator frozen: late presses do not join the chord.
        if (deb_q == 4'b0000) begin
          state_d  = S_EMIT;
          emit_now = 1'b1;
        end
      end
      S_EMIT: begin
        acc_d   = 4'b0000;
        timer_d = '0;
        state_d = S_IDLE;
      end
      default: begin
        acc_d   = 4'b0000;
        timer_d = '0;
        state_d = S_IDLE;
      end
    endcase
    if (emit_now) begin
      if (!lock_active) begin
        btn_d        = acc_d;
        code_valid_d = 1'b1;
      end else begin
        dropped_d = 1'b1;
      end
    end
  end

  // FSM state, accumulator, timer and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      acc_q        <= 4'b0000;
      timer_q      <= '0;
      btn_q        <= 4'b0000;
      code_valid_q <= 1'b0;
      dropped_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      timer_q      <= timer_d;
      btn_q        <= btn_d;
      code_valid_q <= code_valid_d;
      dropped_q    <= dropped_d;
    end
  end

  assign btn        = btn_q;
  assign code_valid = code_valid_q;
  assign dropped    = dropped_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_btn_entry_tx.sv
// Directed self-checking bench for btn_entry_tx (DEBOUNCE_CYCLES=4,
// CHORD_CYCLES=16). Inputs change and outputs are sampled on the falling edge.
module tb_btn_entry_tx;

  logic       clk;
  logic       rst;
  logic [3:0] key_n;
  logic       lock_active;
  logic [3:0] btn;
  logic       code_valid;
  logic       dropped;
  logic       busy;

  int         tests;
  int         fails;
  int         cyc;
  int         ev_cnt;
  int         ev_cyc;
  int         nz_cnt;
  int         drop_cnt;
  int         rel;
  int         wcnt;
  bit         busy_any;
  logic [3:0] last_btn;

  btn_entry_tx #(
    .DEBOUNCE_CYCLES(4),
    .CHORD_CYCLES   (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_n      (key_n),
    .lock_active(lock_active),
    .btn        (btn),
    .code_valid (code_valid),
    .dropped    (dropped),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n cycles, recording emissions and checking invariants each cycle.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (code_valid === 1'b1) begin
        ev_cnt++;
        ev_cyc   = cyc;
        last_btn = btn;
      end
      if (btn !== 4'b0000) nz_cnt++;
      if (dropped === 1'b1) drop_cnt++;
      if (busy === 1'b1) busy_any = 1'b1;
      chk("inv_btn_zero_when_invalid", 32'((code_valid === 1'b1) || (btn === 4'b0000)), 32'd1);
      chk("inv_valid_dropped_excl", 32'((code_valid === 1'b1) && (dropped === 1'b1)), 32'd0);
    end
  endtask

  task automatic clr();
    ev_cnt   = 0;
    ev_cyc   = -1;
    nz_cnt   = 0;
    drop_cnt = 0;
    busy_any = 1'b0;
    last_btn = 4'b0000;
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    cyc         = 0;
    rst         = 1'b0;
    key_n       = 4'b1111;
    lock_active = 1'b0;
    clr();

    // Reset state
    tick(3);
    chk("reset_btn", 32'(btn), 32'h0);
    chk("reset_code_valid", 32'(code_valid), 32'h0);
    chk("reset_dropped", 32'(dropped), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    rst = 1'b1;
    tick(2);

    // 1. Single key, held 12 cycles
    clr();
    key_n = 4'b1110;
    tick(12);
    chk("t1_busy_held", 32'(busy), 32'h1);
    chk("t1_no_emit_while_held", 32'(ev_cnt), 32'd0);
    key_n = 4'b1111;
    rel   = cyc;
    tick(20);
    chk("t1_emit_count", 32'(ev_cnt), 32'd1);
    chk("t1_btn", 32'(last_btn), 32'h1);
    chk("t1_nonzero_cycles", 32'(nz_cnt), 32'd1);
    chk("t1_latency", 32'((ev_cyc - rel >= 6) && (ev_cyc - rel <= 8)), 32'd1);
    chk("t1_busy_after", 32'(busy), 32'h0);

    // 2. Glitch shorter than the debounce window
    clr();
    key_n = 4'b1011;
    tick(3);
    key_n = 4'b1111;
    tick(15);
    chk("t2_busy_never", 32'(busy_any), 32'h0);
    chk("t2_btn_never", 32'(nz_cnt), 32'd0);

    // 3. Chord: key0, then keys 1 and 2 five cycles later, release together
    clr();
    key_n = 4'b1110;
    tick(5);
    key_n = 4'b1000;
    tick(6);
    key_n = 4'b1111;
    tick(20);
    chk("t3_emit_count", 32'(ev_cnt), 32'd1);
    chk("t3_btn", 32'(last_btn), 32'h7);
    chk("t3_nonzero_cycles", 32'(nz_cnt), 32'd1);

    // 4. Key0 pressed after the chord window closed is ignored
    clr();
    key_n = 4'b0111;
    tick(25);
    key_n = 4'b0110;
    tick(10);
    chk("t4_no_emit_while_held", 32'(ev_cnt), 32'd0);
    key_n = 4'b1111;
    rel   = cyc;
    tick(20);
    chk("t4_emit_count", 32'(ev_cnt), 32'd1);
    chk("t4_btn", 32'(last_btn), 32'h8);
    chk("t4_after_release", 32'((ev_cyc - rel >= 6) && (ev_cyc - rel <= 8)), 32'd1);

    // 5. Lockout across the release
    clr();
    lock_active = 1'b1;
    key_n       = 4'b1101;
    tick(12);
    key_n = 4'b1111;
    tick(20);
    lock_active = 1'b0;
    chk("t5_no_valid", 32'(ev_cnt), 32'd0);
    chk("t5_btn_zero", 32'(nz_cnt), 32'd0);
    chk("t5_dropped_pulse", 32'(drop_cnt), 32'd1);

    // 6. Reset in COLLECT with the key still held
    clr();
    key_n = 4'b1110;
    tick(8);
    chk("t6_busy_before_reset", 32'(busy), 32'h1);
    rst = 1'b0;
    tick(1);
    chk("t6_rst_btn", 32'(btn), 32'h0);
    chk("t6_rst_code_valid", 32'(code_valid), 32'h0);
    chk("t6_rst_dropped", 32'(dropped), 32'h0);
    chk("t6_rst_busy", 32'(busy), 32'h0);
    rst  = 1'b1;
    wcnt = 0;
    while ((busy !== 1'b1) && (wcnt < 20)) begin
      tick(1);
      wcnt++;
    end
    chk("t6_redetect_delay", 32'((wcnt >= 6) && (wcnt <= 8)), 32'd1);
    chk("t6_no_emit_abandoned", 32'(ev_cnt + drop_cnt), 32'd0);
    tick(4);
    key_n = 4'b1111;
    tick(20);
    chk("t6_emit_count", 32'(ev_cnt), 32'd1);
    chk("t6_btn", 32'(last_btn), 32'h1);
    chk("t6_busy_after", 32'(busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
